branch_unit: RTL and testbench

- Consumes the ALU status flags (Zero, Neg, Overflow) and resolves conditional branches for the RISC pipeline.
- Holds an architectural flag register and evaluates each branch condition against it.
- On a taken branch, issues a PC redirect to fetch over a valid/ready handshake, then asserts a pipeline flush for a fixed number of cycles.
- Sits in EX, alongside the ALU, between decode (branch requests) and fetch (redirects).

---
 rtl/branch_pkg.sv | 29 ++
 rtl/branch_cond_eval.sv | 26 ++
 rtl/branch_unit.sv | 114 +++++++++++
 tb/tb_branch_unit.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/branch_pkg.sv
// Shared types for the EX-stage branch unit: condition codes, FSM states, flag bundle.
package branch_pkg;

  typedef enum logic [3:0] {
    EQ = 4'd0,
    NE = 4'd1,
    LT = 4'd2,
    GE = 4'd3,
    MI = 4'd4,
    PL = 4'd5,
    VS = 4'd6,
    VC = 4'd7,
    AL = 4'd8,
    NV = 4'd15
  } br_cond_e;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    REDIRECT = 2'd1,
    FLUSH    = 2'd2
  } br_state_e;

  typedef struct packed {
    logic z;
    logic n;
    logic v;
  } flags_t;

endpackage

// File: rtl/branch_cond_eval.sv
// Combinational condition evaluator: flags + 4-bit condition code -> taken.
module branch_cond_eval
  import branch_pkg::*;
(
  input  flags_t     flags,
  input  logic [3:0] cond,
  output logic       taken
);

  always_comb begin
    taken = 1'b0;
    case (cond)
      EQ:      taken = flags.z;
      NE:      taken = !flags.z;
      LT:      taken = flags.n ^ flags.v;
      GE:      taken = !(flags.n ^ flags.v);
      MI:      taken = flags.n;
      PL:      taken = !flags.n;
      VS:      taken = flags.v;
      VC:      taken = !flags.v;
      AL:      taken = 1'b1;
      default: taken = 1'b0; // 9-15 (incl. NV) are never taken
    endcase
  end

endmodule

// File: rtl/branch_unit.sv
// EX-stage branch resolver: flag register, condition check, PC redirect handshake, timed flush.
// Define BRANCH_UNIT_STATS_EN to add saturating taken/not-taken counters.
module branch_unit
  import branch_pkg::*;
#(
  parameter int XLEN         = 32,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            FlagWe,
  input  logic            Zero,
  input  logic            Neg,
  input  logic            Overflow,
  input  logic            BrValid,
  output logic            BrReady,
  input  logic [3:0]      BrCond,
  input  logic [XLEN-1:0] BrPc,
  input  logic [XLEN-1:0] BrOffset,
  output logic            RedirValid,
  input  logic            RedirReady,
  output logic [XLEN-1:0] RedirPc,
  output logic            Flush,
  output logic            Taken
`ifdef BRANCH_UNIT_STATS_EN
  ,
  output logic [31:0]     TakenCnt,
  output logic [31:0]     NotTakenCnt
`endif
);

  localparam int CW = (FLUSH_CYCLES > 2) ? $clog2(FLUSH_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'((FLUSH_CYCLES > 0) ? FLUSH_CYCLES - 1 : 0);

  flags_t          flags_q;
  flags_t          flags_eff;
  logic            cond_taken;
  logic            accept;
  logic [XLEN-1:0] target;
  br_state_e       state;
  logic [CW-1:0]   cnt;

  // Same-cycle flag write is bypassed so a branch right behind its compare sees fresh flags.
  assign flags_eff = FlagWe ? flags_t'({Zero, Neg, Overflow}) : flags_q;

  branch_cond_eval u_eval (
    .flags (flags_eff),
    .cond  (BrCond),
    .taken (cond_taken)
  );

  assign BrReady    = (state == IDLE) && !rst;
  assign accept     = BrValid && BrReady;
  assign Taken      = accept && cond_taken;
  assign RedirValid = (state == REDIRECT);
  assign Flush      = (state != IDLE);
  assign target     = BrPc + BrOffset;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flags_q <= '0;
    end else if (FlagWe) begin
      flags_q <= flags_t'({Zero, Neg, Overflow});
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      RedirPc <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (Taken) begin
            RedirPc <= target;
            state   <= REDIRECT;
          end
        end
        REDIRECT: begin
          if (RedirReady) begin
            if (FLUSH_CYCLES == 0) begin
              state <= IDLE;
            end else begin
              state <= FLUSH;
              cnt   <= CNT_LOAD;
            end
          end
        end
        FLUSH: begin
          if (cnt == '0) state <= IDLE;
          else           cnt   <= cnt - 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef BRANCH_UNIT_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      TakenCnt    <= '0;
      NotTakenCnt <= '0;
    end else if (accept) begin
      if (cond_taken) begin
        if (TakenCnt != 32'hFFFF_FFFF) TakenCnt <= TakenCnt + 32'd1;
      end else begin
        if (NotTakenCnt != 32'hFFFF_FFFF) NotTakenCnt <= NotTakenCnt + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_branch_unit.sv
// Directed bench for branch_unit with a redirect-target scoreboard queue.
module tb_branch_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        FlagWe = 1'b0, Zero = 1'b0, Neg = 1'b0, Overflow = 1'b0;
  logic        BrValid = 1'b0;
  logic        BrReady;
  logic [3:0]  BrCond = 4'd0;
  logic [31:0] BrPc = '0, BrOffset = '0;
  logic        RedirValid;
  logic        RedirReady = 1'b0;
  logic [31:0] RedirPc;
  logic        Flush, Taken;
`ifdef BRANCH_UNIT_STATS_EN
  logic [31:0] TakenCnt, NotTakenCnt;
`endif

  int          total = 0;
  int          bad = 0;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  branch_unit #(.XLEN(32), .FLUSH_CYCLES(2)) dut (
    .clk(clk), .rst(rst), .FlagWe(FlagWe), .Zero(Zero), .Neg(Neg), .Overflow(Overflow),
    .BrValid(BrValid), .BrReady(BrReady), .BrCond(BrCond), .BrPc(BrPc), .BrOffset(BrOffset),
    .RedirValid(RedirValid), .RedirReady(RedirReady), .RedirPc(RedirPc),
    .Flush(Flush), .Taken(Taken)
`ifdef BRANCH_UNIT_STATS_EN
    , .TakenCnt(TakenCnt), .NotTakenCnt(NotTakenCnt)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pops the expected target when fetch actually takes the redirect.
  task automatic wait_redir(input string tag);
    int n = 0;
    logic [31:0] e;
    while (!(RedirValid && RedirReady) && n < 50) begin
      tick();
      n++;
    end
    if (n >= 50) chk({tag, " timeout"}, 32'd0, 32'd1);
    else begin
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
      chk(tag, RedirPc, e);
    end
  endtask

  task automatic count_flush(input string tag, input int exp);
    int n = 0;
    while (Flush && n < 50) begin
      n++;
      tick();
    end
    chk(tag, n, exp);
    chk({tag, " ready"}, {31'b0, BrReady}, 32'd1);
  endtask

  function automatic logic model(input int c, input logic [2:0] f);
    logic z, n, v;
    {z, n, v} = f;
    case (c)
      0: return z;
      1: return !z;
      2: return n ^ v;
      3: return n == v;
      4: return n;
      5: return !n;
      6: return v;
      7: return !v;
      8: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  initial begin
    // reset state
    #2;
    chk("rst ready", {31'b0, BrReady}, 32'd0);
    chk("rst redir", {31'b0, RedirValid}, 32'd0);
    chk("rst flush", {31'b0, Flush}, 32'd0);
    chk("rst taken", {31'b0, Taken}, 32'd0);
    chk("rst pc", RedirPc, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("post-rst ready", {31'b0, BrReady}, 32'd1);
    tick();

    // flag write then EQ branch
    FlagWe = 1'b1; Zero = 1'b1;
    tick();
    FlagWe = 1'b0; Zero = 1'b0;
    BrValid = 1'b1; BrCond = 4'd0; BrPc = 32'h100; BrOffset = 32'h20; RedirReady = 1'b1;
    exp_q.push_back(32'h120);
    #1;
    chk("eq taken", {31'b0, Taken}, 32'd1);
    chk("eq ready", {31'b0, BrReady}, 32'd1);
    tick();
    BrValid = 1'b0;
    chk("eq redir valid", {31'b0, RedirValid}, 32'd1);
    chk("eq taken pulse", {31'b0, Taken}, 32'd0);
    chk("eq ready low", {31'b0, BrReady}, 32'd0);
    wait_redir("eq target");
    count_flush("eq flush len", 3);

    // not-taken back-to-back
    FlagWe = 1'b1; Zero = 1'b0; Neg = 1'b0; Overflow = 1'b0;
    tick();
    FlagWe = 1'b0;
    for (int i = 0; i < 3; i++) begin
      BrValid = 1'b1; BrCond = 4'd0; BrPc = 32'h300 + i * 4;
      #1;
      chk("nt ready", {31'b0, BrReady}, 32'd1);
      chk("nt taken", {31'b0, Taken}, 32'd0);
      tick();
      chk("nt redir", {31'b0, RedirValid}, 32'd0);
      chk("nt flush", {31'b0, Flush}, 32'd0);
    end
    BrValid = 1'b0;

    // same-cycle bypass: registered N=0 would say not-taken
    FlagWe = 1'b1; Neg = 1'b1; Overflow = 1'b0; Zero = 1'b0;
    BrValid = 1'b1; BrCond = 4'd2; BrPc = 32'h200; BrOffset = 32'hFFFF_FFF8;
    exp_q.push_back(32'h1F8);
    #1;
    chk("bypass taken", {31'b0, Taken}, 32'd1);
    tick();
    BrValid = 1'b0; FlagWe = 1'b0;
    wait_redir("bypass target");
    count_flush("bypass flush len", 3);

    // backpressure: MI with registered N=1
    RedirReady = 1'b0;
    BrValid = 1'b1; BrCond = 4'd4; BrPc = 32'h1000; BrOffset = 32'h40;
    exp_q.push_back(32'h1040);
    #1;
    chk("bp taken", {31'b0, Taken}, 32'd1);
    tick();
    BrCond = 4'd8; BrPc = 32'h5000;
    for (int i = 0; i < 4; i++) begin
      chk("bp redir", {31'b0, RedirValid}, 32'd1);
      chk("bp pc stable", RedirPc, 32'h1040);
      chk("bp flush", {31'b0, Flush}, 32'd1);
      chk("bp ready", {31'b0, BrReady}, 32'd0);
      chk("bp ignore br", {31'b0, Taken}, 32'd0);
      tick();
    end
    BrValid = 1'b0; RedirReady = 1'b1;
    wait_redir("bp target");
    count_flush("bp flush len", 3);
`ifdef BRANCH_UNIT_STATS_EN
    chk("cnt taken", TakenCnt, 32'd3);
    chk("cnt nottaken", NotTakenCnt, 32'd3);
`endif

    // wrap-around target, then async reset in FLUSH
    BrValid = 1'b1; BrCond = 4'd8; BrPc = 32'hFFFF_FFF0; BrOffset = 32'h20;
    exp_q.push_back(32'h10);
    tick();
    BrValid = 1'b0;
    wait_redir("wrap target");
    tick();
    chk("wrap in flush", {31'b0, Flush}, 32'd1);
    rst = 1'b1;
    #1;
    chk("arst flush", {31'b0, Flush}, 32'd0);
    chk("arst redir", {31'b0, RedirValid}, 32'd0);
    chk("arst ready", {31'b0, BrReady}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("arst ready back", {31'b0, BrReady}, 32'd1);
    FlagWe = 1'b0;
    BrValid = 1'b1; BrCond = 4'd4;
    #1;
    chk("cleared N (MI)", {31'b0, Taken}, 32'd0);
    BrCond = 4'd5;
    #1;
    chk("cleared N (PL)", {31'b0, Taken}, 32'd1);
    BrCond = 4'd1;
    #1;
    chk("cleared Z (NE)", {31'b0, Taken}, 32'd1);
    BrValid = 1'b0;
    tick();
`ifdef BRANCH_UNIT_STATS_EN
    chk("cnt taken rst", TakenCnt, 32'd0);
    chk("cnt nottaken rst", NotTakenCnt, 32'd0);
`endif

    // codes 0-8 over all flag states, combinational only (dropped before the edge)
    for (int c = 0; c <= 8; c++) begin
      BrCond = 4'(c); BrValid = 1'b1; FlagWe = 1'b1;
      for (int f = 0; f < 8; f++) begin
        {Zero, Neg, Overflow} = 3'(f);
        #1;
        chk($sformatf("cond%0d f%0d", c, f), {31'b0, Taken}, {31'b0, model(c, 3'(f))});
      end
      BrValid = 1'b0; FlagWe = 1'b0;
      tick();
    end

    // codes 9-15 never taken; one accept per code
    for (int c = 9; c <= 15; c++) begin
      BrCond = 4'(c); BrValid = 1'b1; FlagWe = 1'b1;
      for (int f = 0; f < 8; f++) begin
        {Zero, Neg, Overflow} = 3'(f);
        #1;
        chk($sformatf("never%0d f%0d", c, f), {31'b0, Taken}, 32'd0);
      end
      tick();
    end
    BrValid = 1'b0; FlagWe = 1'b0;
    tick();
    chk("never flush", {31'b0, Flush}, 32'd0);
`ifdef BRANCH_UNIT_STATS_EN
    chk("cnt never", NotTakenCnt, 32'd7);
    chk("cnt never taken", TakenCnt, 32'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
